// File: rtl/ex_if.sv
// Handshake and operand/result bundle between instruction decode and the
// execute stage of the RSA ASIP.
interface ex_if #(parameter int ARQ = 16);
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     opcode;
  logic [1:0]     rd_addr;
  logic [ARQ-1:0] op_a;
  logic [ARQ-1:0] op_b;
  logic [ARQ-1:0] op_m;
  logic [9:0]     imm;
  logic           wb_enable;
  logic [ARQ-1:0] wb_result;
  logic [1:0]     wb_addr;
  logic           err;
  logic           busy;

  modport master (
    output in_valid, opcode, rd_addr, op_a, op_b, op_m, imm,
    input  in_ready, wb_enable, wb_result, wb_addr, err, busy
  );

  modport slave (
    input  in_valid, opcode, rd_addr, op_a, op_b, op_m, imm,
    output in_ready, wb_enable, wb_result, wb_addr, err, busy
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle SET/ADD and a square-and-multiply MODEX built on
// a bit-serial interleaved modular multiplier.
//
// state | meaning
// IDLE  | ready for a new instruction
// SQR   | modmul R = R*R mod m, one bit of R per cycle
// MUL   | modmul R = a*R mod m, one bit of a per cycle
// DONE  | write-back strobe, then back to IDLE
module ex_stage (
  input logic clk,
  input logic rst,
  ex_if.slave ex
);
  localparam int ARQ = 16;
  localparam logic [3:0] OP_SET   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_MODEX = 4'b0100;

  typedef enum logic [1:0] {IDLE = 2'd0, SQR = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;

  state_t         state, state_nxt;
  logic [ARQ-1:0] a_q, e_q, m_q, r_q, wb_result_q;
  logic [17:0]    p_q;
  logic [3:0]     j_q, i_q;
  logic [1:0]     rd_q, wb_addr_q;
  logic           err_q;

  logic           accept, modex_run, mm_last, x_bit, e_bit;
  logic [17:0]    m_ext, step0, step1, step2;
  logic [ARQ-1:0] simple_res;
  logic           simple_err;

  assign accept    = ex.in_valid && (state == IDLE);
  assign modex_run = (ex.opcode == OP_MODEX) && (ex.op_m != '0);
  assign mm_last   = (j_q == 4'd0);
  assign e_bit     = e_q[i_q];
  assign x_bit     = (state == MUL) ? a_q[j_q] : r_q[j_q];
  assign m_ext     = {2'b00, m_q};

  // P < m and R < m keep 2P + R below 3m, so two conditional subtracts suffice
  always_comb begin
    step0 = (p_q << 1) + (x_bit ? {2'b00, r_q} : 18'd0);
    step1 = (step0 >= m_ext) ? (step0 - m_ext) : step0;
    step2 = (step1 >= m_ext) ? (step1 - m_ext) : step1;
  end

  always_comb begin
    simple_res = '0;
    simple_err = 1'b0;
    case (ex.opcode)
      OP_SET:  simple_res = {6'b000000, ex.imm};
      OP_ADD:  simple_res = ex.op_a + ex.op_b;
      default: simple_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = modex_run ? SQR : DONE;
      SQR:
        if (mm_last) begin
          if (e_bit)              state_nxt = MUL;
          else if (i_q == 4'd0)   state_nxt = DONE;
          else                    state_nxt = SQR;
        end
      MUL:  if (mm_last) state_nxt = (i_q == 4'd0) ? DONE : SQR;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q         <= '0;
      e_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      p_q         <= '0;
      j_q         <= '0;
      i_q         <= '0;
      rd_q        <= '0;
      wb_result_q <= '0;
      wb_addr_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            a_q  <= ex.op_a;
            e_q  <= ex.op_b;
            m_q  <= ex.op_m;
            rd_q <= ex.rd_addr;
            r_q  <= (ex.op_m == 16'd1) ? 16'd0 : 16'd1;
            p_q  <= '0;
            j_q  <= 4'd15;
            i_q  <= 4'd15;
            if (!modex_run) begin
              wb_result_q <= simple_res;
              wb_addr_q   <= ex.rd_addr;
              err_q       <= simple_err;
            end
          end
        SQR, MUL:
          if (mm_last) begin
            p_q <= '0;
            j_q <= 4'd15;
            r_q <= step2[ARQ-1:0];
            if (state_nxt == SQR) i_q <= i_q - 4'd1;
            if (state_nxt == DONE) begin
              wb_result_q <= step2[ARQ-1:0];
              wb_addr_q   <= rd_q;
              err_q       <= 1'b0;
            end
          end else begin
            p_q <= step2;
            j_q <= j_q - 4'd1;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    ex.in_ready  = (state == IDLE);
    ex.busy      = (state == SQR) || (state == MUL);
    ex.wb_enable = (state == DONE);
    ex.err       = (state == DONE) && err_q;
    ex.wb_result = wb_result_q;
    ex.wb_addr   = wb_addr_q;
  end
endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a queue-based model of
// expected write-backs, busy windows and ready timing.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_if #(.ARQ(16)) bus ();
  ex_stage dut (.clk(clk), .rst(rst), .ex(bus));

  typedef struct {
    logic [15:0] res;
    logic [1:0]  addr;
    logic        err;
    int          done_cyc;
    int          blo;
    int          bhi;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          last_done_cyc = -1;
  logic [15:0] last_res = 16'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  function automatic logic [15:0] model_modexp(input int unsigned a, e, m);
    longint unsigned r, b;
    int unsigned k;
    r = 64'd1 % m;
    b = a % m;
    k = e;
    while (k != 0) begin
      if (k[0]) r = (r * b) % m;
      b = (b * b) % m;
      k = k >> 1;
    end
    return r[15:0];
  endfunction

  // Compare process: every cycle, outputs against the head of the model queue
  always @(negedge clk) begin
    automatic bit exp_wb   = (q.size() > 0) && (cyc == q[0].done_cyc);
    automatic bit exp_busy = (q.size() > 0) && (cyc >= q[0].blo) && (cyc <= q[0].bhi);
    chk("in_ready", bus.in_ready, q.size() == 0);
    chk("busy", bus.busy, exp_busy);
    chk("wb_enable", bus.wb_enable, exp_wb);
    if (exp_wb) begin
      chk("wb_result", bus.wb_result, q[0].res);
      chk("wb_addr", bus.wb_addr, q[0].addr);
      chk("err", bus.err, q[0].err);
      last_res = q[0].res;
      last_done_cyc = cyc;
      void'(q.pop_front());
    end else begin
      chk("wb_result_hold", bus.wb_result, last_res);
      chk("err_idle", bus.err, 1'b0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] rd,
                       input logic [15:0] a, b, m, input logic [9:0] im,
                       output int acc);
    exp_t x;
    int n, guard;
    guard = 0;
    acc = -1;
    @(negedge clk);
    while (!(q.size() == 0 && cyc != last_done_cyc)) begin
      guard++;
      if (guard > 2000) begin
        timeout("issue_ready");
        return;
      end
      @(negedge clk);
    end
    bus.opcode = op; bus.rd_addr = rd; bus.op_a = a; bus.op_b = b;
    bus.op_m = m; bus.imm = im; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.in_valid = 1'b0;
    bus.opcode = 4'($urandom); bus.rd_addr = 2'($urandom);
    bus.op_a = 16'($urandom); bus.op_b = 16'($urandom);
    bus.op_m = 16'($urandom); bus.imm = 10'($urandom);
    x.addr = rd;
    x.err = 1'b0;
    n = 0;
    if (op == 4'b0000)      x.res = {6'b0, im};
    else if (op == 4'b0001) x.res = 16'((32'(a) + 32'(b)) % 65536);
    else if (op == 4'b0100 && m != 0) begin
      x.res = model_modexp(a, b, m);
      n = 16 * (16 + $countones(b));
    end else begin
      x.res = 16'h0;
      x.err = 1'b1;
    end
    x.done_cyc = acc + n;
    x.blo = acc;
    x.bhi = acc + n - 1;
    q.push_back(x);
  endtask

  // Hand-computed expectation for a directed instruction, cycle counted from accept
  task automatic expect_wb(input int acc, input logic [15:0] lr, input logic [1:0] la,
                           input logic le, input int lcyc, input bit poke,
                           output int dcyc);
    int guard;
    guard = 0;
    dcyc = -1;
    @(negedge clk);
    while (!bus.wb_enable) begin
      if (poke) begin
        bus.in_valid = 1'($urandom);
        bus.opcode = 4'b0000;
      end
      guard++;
      if (guard > 2000) begin
        bus.in_valid = 1'b0;
        timeout("expect_wb");
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    dcyc = cyc;
    chk("lit_cycle", cyc - acc + 1, lcyc);
    chk("lit_result", bus.wb_result, lr);
    chk("lit_addr", bus.wb_addr, la);
    chk("lit_err", bus.err, le);
  endtask

  task automatic check_reset_outputs();
    chk("rst_wb_enable", bus.wb_enable, 0);
    chk("rst_wb_result", bus.wb_result, 0);
    chk("rst_wb_addr", bus.wb_addr, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, dcyc, r, k;
    logic [3:0] op;
    logic [15:0] m;
    bus.in_valid = 1'b0; bus.opcode = 4'h0; bus.rd_addr = 2'd0;
    bus.op_a = 16'h0; bus.op_b = 16'h0; bus.op_m = 16'h0; bus.imm = 10'h0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // MODEX aborted by reset at cycle 100, with a SET presented in the reset cycle
    issue(4'b0100, 2'd0, 16'd19, 16'd17, 16'd16, 10'd0, acc);
    while (cyc - acc + 1 < 100) @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.opcode = 4'b0000; bus.imm = 10'h155; bus.rd_addr = 2'd3;
    @(posedge clk);
    #1;
    q.delete();
    last_res = 16'h0;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (300) @(negedge clk);

    issue(4'b0000, 2'd2, 16'h0, 16'h0, 16'h0, 10'h3FF, acc);
    expect_wb(acc, 16'h03FF, 2'd2, 1'b0, 1, 1'b0, dcyc);

    issue(4'b0001, 2'd1, 16'hFFFF, 16'h0002, 16'h0, 10'h0, acc);
    expect_wb(acc, 16'h0001, 2'd1, 1'b0, 1, 1'b0, dcyc);

    issue(4'b0100, 2'd0, 16'd19, 16'd17, 16'd16, 10'h0, acc);
    expect_wb(acc, 16'd3, 2'd0, 1'b0, 289, 1'b1, dcyc);

    issue(4'b0100, 2'd3, 16'd4, 16'd13, 16'd497, 10'h0, acc);
    expect_wb(acc, 16'd445, 2'd3, 1'b0, 305, 1'b0, dcyc);
    issue(4'b0000, 2'd1, 16'h0, 16'h0, 16'h0, 10'd5, acc2);
    chk("b2b_accept_edge", acc2, dcyc + 2);
    expect_wb(acc2, 16'd5, 2'd1, 1'b0, 1, 1'b0, dcyc);

    issue(4'b0100, 2'd2, 16'd123, 16'd0, 16'd7, 10'h0, acc);
    expect_wb(acc, 16'd1, 2'd2, 1'b0, 257, 1'b0, dcyc);
    issue(4'b0100, 2'd1, 16'd55, 16'd999, 16'd1, 10'h0, acc);
    expect_wb(acc, 16'd0, 2'd1, 1'b0, 385, 1'b0, dcyc);
    issue(4'b0100, 2'd3, 16'd0, 16'd5, 16'd9, 10'h0, acc);
    expect_wb(acc, 16'd0, 2'd3, 1'b0, 289, 1'b0, dcyc);
    issue(4'b0100, 2'd0, 16'd77, 16'd3, 16'd0, 10'h0, acc);
    expect_wb(acc, 16'd0, 2'd0, 1'b1, 1, 1'b0, dcyc);

    issue(4'b1111, 2'd2, 16'd1, 16'd2, 16'd3, 10'h3, acc);
    expect_wb(acc, 16'd0, 2'd2, 1'b1, 1, 1'b0, dcyc);
    issue(4'b0001, 2'd3, 16'd1000, 16'd234, 16'd0, 10'h0, acc);
    expect_wb(acc, 16'd1234, 2'd3, 1'b0, 1, 1'b0, dcyc);

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = 4'b0000;
      else if (r < 6) op = 4'b0001;
      else if (r < 9) op = 4'b0100;
      else begin
        op = 4'($urandom);
        while (op == 4'b0000 || op == 4'b0001 || op == 4'b0100) op = 4'($urandom);
      end
      k = $urandom_range(0, 7);
      if (k == 0)      m = 16'd0;
      else if (k == 1) m = 16'd1;
      else if (k == 2) m = 16'($urandom_range(2, 255));
      else             m = 16'($urandom);
      issue(op, 2'($urandom), 16'($urandom), 16'($urandom), m, 10'($urandom), acc);
    end

    k = 0;
    while (q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) timeout("drain");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit RSA ASIP, directly downstream of the instruction-decode stage (ID). It consumes the decoded opcode, destination register, three register operands and 10-bit immediate, and produces one write-back result per instruction. SET and ADD complete in one cycle. MODEX computes a^e mod m with a multi-cycle square-and-multiply engine built on a bit-serial interleaved modular multiplier, and holds off ID through a ready handshake.

## Interface
- ARQ, 16, datapath width; the latency formulas below hold only for 16.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  ID presents an instruction.
- in_ready  output  1  stage can accept; high exactly when the state is IDLE.
- opcode  input  4  0000 SET, 0001 ADD, 0100 MODEX; any other value is illegal.
- rd_addr  input  2  destination register, forwarded to wb_addr.
- op_a  input  ARQ  MODEX base a / ADD operand.
- op_b  input  ARQ  MODEX exponent e / ADD operand.
- op_m  input  ARQ  MODEX modulus m.
- imm  input  10  SET immediate.
- wb_enable  output  1  one-cycle write-back strobe.
- wb_result  output  ARQ  result; valid while wb_enable is high, holds its value otherwise.
- wb_addr  output  2  destination register for wb_result.
- err  output  1  high with wb_enable for an illegal opcode or m == 0.
- busy  output  1  high in SQR or MUL.

## Operation
- States: IDLE, SQR, MUL, DONE.
- Accept: in_valid && in_ready at a rising edge. All inputs are latched at that edge; later changes to the inputs are ignored.
- SET: result = {6'b0, imm}. Next state is DONE.
- ADD: result = (op_a + op_b) mod 2^16; the carry is dropped. Next state is DONE.
- Illegal opcode: result = 0, err = 1. Next state is DONE.
- MODEX with m == 0: result = 0, err = 1. Next state is DONE.
- MODEX with m != 0:
  - Initialise R = (m == 1) ? 0 : 1 and exponent bit index i = 15.
  - Go to SQR.
- SQR computes R = modmul(x = R, y = R).
  - When it finishes: if e[i] = 1, go to MUL; otherwise, if i = 0 go to DONE, else decrement i and go to SQR.
- MUL computes R = modmul(x = a, y = R).
  - When it finishes: if i = 0 go to DONE, else decrement i and go to SQR.
- modmul(x, y), with y < m:
  - Takes exactly 16 cycles, one bit of x per cycle, MSB first.
  - Accumulator P is 18 bits and starts at 0.
  - Each cycle: P = 2P + (x[j] ? y : 0), then subtract m at most twice until P < m.
  - Because x is consumed bitwise, a needs no pre-reduction (any a in 0..65535 is legal).
- DONE: wb_enable = 1, wb_result = result, wb_addr = latched rd_addr, err as computed. Next state is IDLE.
- Degenerate cases: e == 0 gives 1 (or 0 when m == 1); m == 1 gives 0 for any a and e; a == 0 with e != 0 gives 0.

## Timing
- The acceptance edge is cycle 0.
- SET, ADD, illegal opcode, m == 0: wb_enable is high in cycle 1, and in_ready is high again in cycle 2.
- MODEX with m != 0: N = 16·(16 + popcount(e)) cycles in SQR/MUL, then wb_enable high in cycle N+1.
- busy is high in cycles 1..N.
- in_ready is low from cycle 1 through the DONE cycle. in_valid is ignored while in_ready is low.
- Back-to-back: a new instruction may be accepted on the first edge where the state is IDLE.
- Reset (rst low at an edge):
  - state = IDLE, wb_enable = 0, wb_result = 0, wb_addr = 0, err = 0, busy = 0; in_ready = 1 from that edge.
  - Any MODEX in flight is discarded and produces no write-back.
  - An instruction presented during the reset cycle is not accepted.
- in_valid and rst asserted in the same cycle: reset wins.

## Test plan
- Reset mid-MODEX: start a MODEX, pull rst low at cycle 100 → wb_enable never pulses, all outputs are 0, in_ready = 1 after that edge. Then SET imm = 10'h3FF, rd = 2 → wb_enable in cycle 1, wb_result = 16'h03FF, wb_addr = 2, err = 0.
- ADD: 16'hFFFF + 16'h0002, rd = 1 → wb_result = 16'h0001, one-cycle latency, err = 0.
- MODEX a = 19, e = 17, m = 16, rd = 0:
  - wb_result = 3, with wb_enable exactly in cycle 289 (N = 288).
  - busy is high in cycles 1..288; in_valid pulses during that window are not accepted.
- MODEX a = 4, e = 13, m = 497 → wb_result = 445 in cycle 305. Immediately follow with SET → it is accepted on the first IDLE edge.
- Degenerate MODEX:
  - e = 0, m = 7 → 1 in cycle 257.
  - m = 1 → 0.
  - m = 0 → 0 with err = 1 in cycle 1.
- Illegal opcode 4'b1111 → wb_result = 0, err = 1, wb_enable in cycle 1. The next legal instruction has err = 0.
